t_ff: RTL and testbench
=======================

# t_ff

Synchronous toggle flip-flop with complementary outputs: on each rising clock edge the stored bit inverts when the toggle input is high and holds otherwise. It is a leaf primitive for counters, clock-enable dividers and parity/state bits. It is parameterised so a vector of independent toggle cells can be built from one instance. The default configuration is a single-bit T flip-flop.

## Interface

Clock and reset: one clock; reset is synchronous and active-low. The clock port is `clk` and the reset port is `rst`.

Parameters:
- WIDTH, default 1: number of independent toggle cells; bit i of every data port belongs to cell i.
- RESET_VALUE, default all zeros (WIDTH bits): value loaded into `q` on reset and at power-up.

Ports, in positional order:
- clk, input, 1: clock; all state changes occur on its rising edge only.
- rst, input, 1: synchronous active-low reset; 0 loads RESET_VALUE at the next rising edge.
- t, input, WIDTH: toggle control per cell; 1 inverts that cell's state at the next rising edge.
- q, output, WIDTH: registered state.
- qb, output, WIDTH: complement of `q`, equal to `~q` at all times.

## Operation

- Evaluation at each rising edge of `clk`, per cell i:
  - If `rst` == 0: `q[i]` is set to `RESET_VALUE[i]`. Reset has priority over `t`.
  - Else if `t[i]` == 1: `q[i]` is set to `~q[i]`.
  - Else: `q[i]` holds its value.
- `qb` is driven combinationally as `~q`. It is never separately registered, so `q` and `qb` are never equal.
- Power-up / time-zero value: `q` = RESET_VALUE and `qb` = ~RESET_VALUE. A toggle issued before any reset therefore produces a defined result and never X.
- Cells are fully independent; there is no carry or interaction between bits.
- No internal state exists other than `q`, and there is no FSM.

## Timing

- Latency is 1 clock. A `t` or `rst` value sampled at edge N is visible on `q`/`qb` immediately after edge N.
- Reset is synchronous:
  - Asserting `rst` between edges has no effect until the next rising edge.
  - Deasserting `rst` takes effect at the first edge that samples `rst` == 1; `t` is honoured at that same edge.
- Reset held for multiple cycles keeps `q` = RESET_VALUE regardless of `t`.
- Holding `t` == 1 continuously makes `q` a divide-by-2 of `clk`, changing every edge.
- Inputs must meet setup/hold relative to the rising edge; there is no combinational path from `t` or `rst` to `q`.

## Test plan

- Hold, default params:
  - Stimulus: time-zero state, `rst`=1, `t`=0 for 5 rising edges.
  - Required: `q`=0 and `qb`=1 throughout.
- Toggle run:
  - Stimulus: `rst`=1, `t`=1 for 5 edges, starting from `q`=0.
  - Required: `q` sequence 1,0,1,0,1; final `q`=1, `qb`=0; `qb` equals `~q` after every edge.
- Hold then toggle:
  - Stimulus: `t`=0 for 5 edges, then `t`=1 for 5 edges, starting from `q`=1.
  - Required: `q` stays 1 during the hold, then follows 0,1,0,1,0.
- Reset priority:
  - Stimulus: with `q`=1, drive `rst`=0 and alternate `t` between 0 and 1 for 10 edges.
  - Required: `q`=0 from the first edge with `rst`=0 and stays 0; `qb`=1.
- Reset release with toggle:
  - Stimulus: deassert `rst` (to 1) with `t`=1 already high.
  - Required: `q` becomes 1 at the first edge sampling `rst`=1.
- Vector variant:
  - Stimulus: WIDTH=4, RESET_VALUE=4'b1010; reset, then `t`=4'b0110 for one edge.
  - Required: `q`=4'b1010 after reset, then `q`=4'b1100 and `qb`=4'b0011.

Source files
------------

// File: rtl/t_ff.sv
// Toggle flip-flop bank with complementary outputs: each cell inverts on its
// t bit at the rising clock edge; synchronous active-low reset wins over t.
module t_ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  // Declaration initialiser gives a defined power-up value, so a toggle
  // before the first reset never produces X.
  logic [WIDTH-1:0] state = RESET_VALUE;

  // NOTE: sequential state uses non-blocking (<=) so every cell samples its
  // pre-edge value; blocking here would let downstream logic race the update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RESET_VALUE;
    end else begin
      state <= state ^ t;
    end
  end

  // qb is derived from the same register, never a second flop, so q and qb
  // can never disagree.
  assign q  = state;
  assign qb = ~state;

endmodule

// File: tb/tb_t_ff.sv
// Directed bench for t_ff: a default single-bit instance and a 4-bit instance
// with a non-zero reset value, checked with immediate assertions.
module tb_t_ff;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic       t1;
  logic [3:0] t4;
  logic       q1, qb1;
  logic [3:0] q4, qb4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic exp1;

  always #5 clk = ~clk;

  t_ff dut1 (
    .clk (clk),
    .rst (rst1),
    .t   (t1),
    .q   (q1),
    .qb  (qb1)
  );

  t_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
    .clk (clk),
    .rst (rst4),
    .t   (t4),
    .q   (q4),
    .qb  (qb4)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag);
    check({tag, " q"},  {3'b0, q1},  {3'b0, exp1});
    check({tag, " qb"}, {3'b0, qb1}, {3'b0, ~exp1});
  endtask

  initial begin
    rst1 = 1'b1;
    t1   = 1'b0;
    rst4 = 1'b1;
    t4   = 4'b0000;
    exp1 = 1'b0;
    #1;

    // Power-up values without any reset
    check1("powerup");
    check("powerup q4",  q4,  4'b1010);
    check("powerup qb4", qb4, 4'b0101);

    // Hold at zero
    for (int i = 0; i < 5; i++) begin
      step();
      check1("hold0");
    end

    // Toggle run: 1,0,1,0,1
    t1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp1 = ~exp1;
      check1("toggle");
    end
    check("toggle final", {3'b0, q1}, 4'b0001);

    // Hold at one, then toggle 0,1,0,1,0
    t1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check1("hold1");
    end
    t1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      exp1 = ~exp1;
      check1("hold_toggle");
    end
    check("hold_toggle final", {3'b0, q1}, 4'b0000);

    // One more toggle to get q=1, then assert reset mid-cycle: no effect yet
    step();
    exp1 = 1'b1;
    check1("pre_reset");
    rst1 = 1'b0;
    t1   = 1'b0;
    #2;
    check1("sync_reset_midcycle");

    // Reset priority over alternating t
    exp1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check1("reset_priority");
      t1 = ~t1;
    end

    // Release with t already high: toggle honoured on the release edge
    t1   = 1'b1;
    rst1 = 1'b1;
    step();
    exp1 = 1'b1;
    check1("release_toggle");

    // Vector instance: reset, then independent per-cell toggles
    t4   = 4'b0101;
    rst4 = 1'b0;
    step();
    check("vec reset q4",  q4,  4'b1010);
    check("vec reset qb4", qb4, 4'b0101);
    rst4 = 1'b1;
    t4   = 4'b0110;
    step();
    check("vec toggle q4",  q4,  4'b1100);
    check("vec toggle qb4", qb4, 4'b0011);
    t4 = 4'b0000;
    step();
    check("vec hold q4", q4, 4'b1100);
    t4 = 4'b1111;
    step();
    check("vec all q4",  q4,  4'b0011);
    check("vec all qb4", qb4, 4'b1100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
